// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: write-back source selects and memory-stage FSM states
package mem_stage_pkg;
  localparam logic [2:0] WB_MEM   = 3'd0;
  localparam logic [2:0] WB_ALU   = 3'd1;
  localparam logic [2:0] WB_PC    = 3'd2;
  localparam logic [2:0] WB_SET   = 3'd3;
  localparam logic [2:0] WB_SEXT8 = 3'd4;
  localparam logic [2:0] WB_SLBI  = 3'd5;
  localparam logic [2:0] WB_BTR   = 3'd6;
  typedef enum logic [1:0] {IDLE, BUSY, HALTED} state_t;
endpackage

// File: rtl/mem_stage_stall_wb_mux.sv
// wb_mux: seven-source write-back selector; select 7 yields zero and flags illegal
module wb_mux import mem_stage_pkg::*; #(
  parameter int DATA_W = 16
) (
  input  logic [2:0]        i_src,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_next_pc,
  input  logic [DATA_W-1:0] i_set_val,
  input  logic [DATA_W-1:0] i_reg1,
  input  logic [7:0]        i_imm8,
  output logic [DATA_W-1:0] o_value,
  output logic              o_illegal
);
  logic [DATA_W-1:0] w_rev;
  for (genvar i = 0; i < DATA_W; i++) begin : g_rev
    assign w_rev[i] = i_reg1[DATA_W-1-i];
  end
  assign o_illegal = i_src == 3'd7;
  assign o_value = i_src == WB_MEM   ? i_mem_rdata :
                   i_src == WB_ALU   ? i_alu :
                   i_src == WB_PC    ? i_next_pc :
                   i_src == WB_SET   ? i_set_val :
                   i_src == WB_SEXT8 ? {{(DATA_W-8){i_imm8[7]}}, i_imm8} :
                   i_src == WB_SLBI  ? {i_reg1[DATA_W-9:0], i_imm8} :
                   i_src == WB_BTR   ? w_rev : '0;
endmodule

// File: rtl/mem_stage_stall.sv
// mem_stage_stall: memory stage driving a stalling req/done data memory, with timeout and halt dump
module mem_stage_stall import mem_stage_pkg::*; #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic              halt,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] reg1_data,
  input  logic [DATA_W-1:0] reg2_data,
  input  logic [DATA_W-1:0] next_pc,
  input  logic [DATA_W-1:0] set_val,
  input  logic [15:0]       instr,
  input  logic [2:0]        wb_src_in,
  input  logic              reg_wrt_in,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              mem_createdump,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_wb_data,
  output logic              out_reg_wrt,
  output logic              err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_src;
  logic              r_reg_wrt;
  logic [DATA_W-1:0] r_alu, r_next_pc, r_set_val, r_reg1;
  logic [7:0]        r_imm8;
  logic              r_valid, r_wrt, r_err, r_dump;
  logic [DATA_W-1:0] r_wb;
  logic              w_idle, w_busy, w_issue, w_pass, w_halt, w_done, w_timeout, w_err_set;
  logic              w_ill, w_reg_wrt, w_unused;
  logic [DATA_W-1:0] w_alu, w_value;
  assign w_unused  = &{1'b0, instr[15:8]};
  assign w_alu     = DATA_W'(alu_out);
  assign w_idle    = rst && r_state == IDLE;
  assign w_busy    = rst && r_state == BUSY;
  assign w_issue   = w_idle && in_valid && mem_en;
  assign w_pass    = w_idle && in_valid && !mem_en;
  assign w_halt    = w_pass && halt;
  assign w_done    = w_busy && mem_done;
  assign w_timeout = w_busy && !mem_done && r_cnt == CNT_W'(TIMEOUT - 1);
  assign w_reg_wrt = w_busy ? r_reg_wrt : reg_wrt_in;
  assign w_err_set = w_timeout || (w_idle && in_valid && w_ill);
  // The timed-out instruction is dropped, so upstream is released in that cycle.
  assign stall     = w_issue || (w_busy && !mem_done && !w_timeout);
  assign mem_req   = w_issue;
  assign mem_wr_o  = w_issue && mem_wr;
  assign mem_addr  = alu_out;
  assign mem_wdata = reg2_data;
  assign mem_createdump = r_dump;
  assign out_valid      = r_valid;
  assign out_wb_data    = r_wb;
  assign out_reg_wrt    = r_wrt;
  assign err            = r_err;
  wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
    .i_src       (w_busy ? r_src : wb_src_in),
    .i_mem_rdata (mem_rdata),
    .i_alu       (w_busy ? r_alu : w_alu),
    .i_next_pc   (w_busy ? r_next_pc : next_pc),
    .i_set_val   (w_busy ? r_set_val : set_val),
    .i_reg1      (w_busy ? r_reg1 : reg1_data),
    .i_imm8      (w_busy ? r_imm8 : instr[7:0]),
    .o_value     (w_value),
    .o_illegal   (w_ill)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_src     <= '0;
      r_reg_wrt <= 1'b0;
      r_alu     <= '0;
      r_next_pc <= '0;
      r_set_val <= '0;
      r_reg1    <= '0;
      r_imm8    <= '0;
      r_valid   <= 1'b0;
      r_wrt     <= 1'b0;
      r_wb      <= '0;
      r_err     <= 1'b0;
      r_dump    <= 1'b0;
    end else begin
      r_valid <= w_pass || w_done;
      r_wrt   <= (w_pass || w_done) && w_reg_wrt && !w_ill;
      if (w_pass || w_done) r_wb <= w_value;
      r_err   <= r_err || w_err_set;
      r_dump  <= w_halt || (w_err_set && !r_err);
      r_cnt   <= w_busy ? r_cnt + CNT_W'(1) : '0;
      if (w_issue) begin
        r_src     <= wb_src_in;
        r_reg_wrt <= reg_wrt_in;
        r_alu     <= w_alu;
        r_next_pc <= next_pc;
        r_set_val <= set_val;
        r_reg1    <= reg1_data;
        r_imm8    <= instr[7:0];
      end
      r_state <= w_halt ? HALTED : w_issue ? BUSY : (w_done || w_timeout) ? IDLE : r_state;
    end
  end
endmodule

// File: tb/tb_mem_stage_stall.sv
// tb_mem_stage_stall: scoreboard bench for the stalling memory stage (TIMEOUT=4)
module tb_mem_stage_stall;
  localparam int DW = 16, AW = 16, TO = 4;
  logic clk = 0, rst = 0;
  logic in_valid, mem_en, mem_wr, halt, reg_wrt_in, mem_done;
  logic [AW-1:0] alu_out, mem_addr;
  logic [DW-1:0] reg1_data, reg2_data, next_pc, set_val, mem_wdata, mem_rdata, out_wb_data;
  logic [15:0] instr;
  logic [2:0] wb_src_in;
  logic stall, mem_req, mem_wr_o, mem_createdump, out_valid, out_reg_wrt, err;
  typedef struct {logic [DW-1:0] d; logic w; logic c;} exp_t;
  exp_t q[$];
  exp_t e_mon;
  int n_cmp = 0, n_bad = 0, n_dump = 0;

  always #5 clk = ~clk;

  mem_stage_stall #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_en(mem_en), .mem_wr(mem_wr), .halt(halt),
    .alu_out(alu_out), .reg1_data(reg1_data), .reg2_data(reg2_data), .next_pc(next_pc),
    .set_val(set_val), .instr(instr), .wb_src_in(wb_src_in), .reg_wrt_in(reg_wrt_in),
    .stall(stall), .mem_req(mem_req), .mem_wr_o(mem_wr_o), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .mem_createdump(mem_createdump), .out_valid(out_valid), .out_wb_data(out_wb_data),
    .out_reg_wrt(out_reg_wrt), .err(err)
  );

  // Scoreboard: every MEM/WB result is matched against the oldest pushed expectation.
  always @(negedge clk) begin
    if (mem_createdump === 1'b1) n_dump++;
    n_cmp++;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_extra: out_valid=1 data=%h wrt=%b, no result expected", out_wb_data, out_reg_wrt);
      end else begin
        e_mon = q.pop_front();
        if (out_reg_wrt !== e_mon.w || (e_mon.c && out_wb_data !== e_mon.d)) begin
          n_bad++;
          $display("FAIL sb_result: got data=%h wrt=%b, expected data=%h wrt=%b", out_wb_data, out_reg_wrt, e_mon.d, e_mon.w);
        end
      end
    end else if (out_reg_wrt !== 1'b0) begin
      n_bad++;
      $display("FAIL sb_wrt_idle: out_valid=%b out_reg_wrt=%b, expected out_reg_wrt=0", out_valid, out_reg_wrt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 0; mem_en = 0; mem_wr = 0; halt = 0; reg_wrt_in = 0; mem_done = 0;
    alu_out = '0; reg1_data = '0; reg2_data = '0; next_pc = '0; set_val = '0;
    instr = '0; wb_src_in = '0; mem_rdata = '0;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic w, input logic c);
    exp_t e;
    e.d = d; e.w = w; e.c = c;
    q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 0; in_valid = 1; mem_en = 1; wb_src_in = 3'd1;
    tick(); tick();
    n_cmp++;
    if ({mem_req, stall, out_valid, out_reg_wrt, err, mem_createdump} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: req/stall/valid/wrt/err/dump=%b, expected 000000",
               {mem_req, stall, out_valid, out_reg_wrt, err, mem_createdump});
    end
    n_cmp++;
    if (out_wb_data !== 16'h0) begin
      n_bad++; $display("FAIL reset_wb_data: got %h, expected 0000", out_wb_data);
    end
    idle_in(); rst = 1;
    tick();
    n_cmp++;
    if (stall !== 0 || mem_req !== 0 || out_valid !== 0) begin
      n_bad++; $display("FAIL reset_release: stall=%b req=%b valid=%b, expected 0 0 0", stall, mem_req, out_valid);
    end
  endtask

  task automatic test_alu();
    in_valid = 1; wb_src_in = 3'd1; alu_out = 16'h1234; reg_wrt_in = 1;
    push(16'h1234, 1, 1);
    #1;
    n_cmp++;
    if (stall !== 0 || mem_req !== 0) begin
      n_bad++; $display("FAIL alu_no_stall: stall=%b req=%b, expected 0 0", stall, mem_req);
    end
    tick(); idle_in();
    n_cmp++;
    if (out_valid !== 1 || out_wb_data !== 16'h1234 || out_reg_wrt !== 1) begin
      n_bad++; $display("FAIL alu_result: valid=%b data=%h wrt=%b, expected 1 1234 1", out_valid, out_wb_data, out_reg_wrt);
    end
    tick();
    n_cmp++;
    if (out_valid !== 0) begin
      n_bad++; $display("FAIL alu_idle: out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_load();
    in_valid = 1; mem_en = 1; mem_wr = 0; alu_out = 16'h0040; reg2_data = 16'h7777;
    wb_src_in = 3'd0; reg_wrt_in = 1;
    #1;
    n_cmp++;
    if (mem_req !== 1 || mem_addr !== 16'h0040 || mem_wr_o !== 0 || stall !== 1) begin
      n_bad++; $display("FAIL load_issue: req=%b addr=%h wr=%b stall=%b, expected 1 0040 0 1", mem_req, mem_addr, mem_wr_o, stall);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin
        mem_done = 1; mem_rdata = 16'hBEEF; push(16'hBEEF, 1, 1);
      end
      #1;
      n_cmp++;
      if (mem_req !== 0 || stall !== (i < 2) || out_valid !== 0) begin
        n_bad++; $display("FAIL load_busy%0d: req=%b stall=%b valid=%b, expected 0 %b 0", i, mem_req, stall, out_valid, i < 2);
      end
    end
    tick(); idle_in();
    n_cmp++;
    if (out_valid !== 1 || out_wb_data !== 16'hBEEF) begin
      n_bad++; $display("FAIL load_result: valid=%b data=%h, expected 1 beef", out_valid, out_wb_data);
    end
    mem_done = 1; mem_rdata = 16'h1111;
    tick(); mem_done = 0;
    n_cmp++;
    if (out_valid !== 0) begin
      n_bad++; $display("FAIL idle_done_ignored: out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  s   [7] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [15:0] r1  [7] = '{16'h0, 16'h0, 16'h0, 16'h1234, 16'h00F1, 16'h0, 16'h0003};
    logic [15:0] ins [7] = '{16'h0, 16'h0, 16'h0080, 16'h00AB, 16'h0, 16'h117F, 16'h0};
    logic [15:0] ex  [7] = '{16'h0102, 16'h0001, 16'hFF80, 16'h34AB, 16'h8F00, 16'h007F, 16'hC000};
    for (int i = 0; i < 7; i++) begin
      in_valid = 1; wb_src_in = s[i]; next_pc = 16'h0102; set_val = 16'h0001;
      reg1_data = r1[i]; instr = ins[i]; reg_wrt_in = (i % 2 == 0);
      push(ex[i], i % 2 == 0, 1);
      #1;
      n_cmp++;
      if (stall !== 0) begin
        n_bad++; $display("FAIL b2b_stall%0d: stall=%b, expected 0", i, stall);
      end
      tick();
    end
    idle_in();
    tick();
    in_valid = 1; mem_en = 1; mem_wr = 1; alu_out = 16'h0100; reg2_data = 16'hCAFE; wb_src_in = 3'd0;
    #1;
    n_cmp++;
    if (mem_req !== 1 || mem_wr_o !== 1 || mem_wdata !== 16'hCAFE || mem_addr !== 16'h0100) begin
      n_bad++; $display("FAIL store_issue: req=%b wr=%b wdata=%h addr=%h, expected 1 1 cafe 0100", mem_req, mem_wr_o, mem_wdata, mem_addr);
    end
    tick();
    mem_done = 1; push(16'h0, 0, 0);
    #1;
    n_cmp++;
    if (stall !== 0) begin
      n_bad++; $display("FAIL store_done_stall: stall=%b, expected 0", stall);
    end
    tick(); idle_in();
    n_cmp++;
    if (out_valid !== 1 || out_reg_wrt !== 0) begin
      n_bad++; $display("FAIL store_result: valid=%b wrt=%b, expected 1 0", out_valid, out_reg_wrt);
    end
    tick();
  endtask

  task automatic test_illegal();
    in_valid = 1; wb_src_in = 3'd7; reg_wrt_in = 1; alu_out = 16'hFFFF;
    push(16'h0, 0, 1);
    tick(); idle_in();
    n_cmp++;
    if (err !== 1 || mem_createdump !== 1 || out_wb_data !== 16'h0 || out_reg_wrt !== 0) begin
      n_bad++; $display("FAIL illegal_src: err=%b dump=%b data=%h wrt=%b, expected 1 1 0000 0", err, mem_createdump, out_wb_data, out_reg_wrt);
    end
    tick();
    n_cmp++;
    if (err !== 1 || mem_createdump !== 0) begin
      n_bad++; $display("FAIL err_sticky: err=%b dump=%b, expected 1 0", err, mem_createdump);
    end
  endtask

  task automatic do_reset();
    rst = 0; idle_in();
    tick(); rst = 1;
    tick();
    n_cmp++;
    if (err !== 0) begin
      n_bad++; $display("FAIL reset_clears_err: err=%b, expected 0", err);
    end
  endtask

  task automatic test_timeout();
    in_valid = 1; mem_en = 1; alu_out = 16'h0200; wb_src_in = 3'd0; reg_wrt_in = 1;
    for (int i = 0; i < TO; i++) begin
      tick();
      n_cmp++;
      if (err !== 0 || out_valid !== 0 || mem_req !== 0 || (i < TO - 1 && stall !== 1)) begin
        n_bad++; $display("FAIL timeout_wait%0d: err=%b valid=%b req=%b stall=%b, expected 0 0 0 1", i, err, out_valid, mem_req, stall);
      end
    end
    tick(); idle_in();
    #1;
    n_cmp++;
    if (err !== 1 || mem_createdump !== 1 || out_valid !== 0 || stall !== 0) begin
      n_bad++; $display("FAIL timeout_fire: err=%b dump=%b valid=%b stall=%b, expected 1 1 0 0", err, mem_createdump, out_valid, stall);
    end
    mem_done = 1; mem_rdata = 16'h2222;
    tick(); mem_done = 0;
    n_cmp++;
    if (out_valid !== 0 || mem_createdump !== 0 || err !== 1) begin
      n_bad++; $display("FAIL timeout_after: valid=%b dump=%b err=%b, expected 0 0 1", out_valid, mem_createdump, err);
    end
  endtask

  task automatic test_reset_mid_busy();
    in_valid = 1; mem_en = 1; alu_out = 16'h0300; wb_src_in = 3'd0; reg_wrt_in = 1;
    tick(); tick();
    rst = 0;
    #1;
    n_cmp++;
    if ({mem_req, stall, out_valid, out_reg_wrt, err, mem_createdump} !== 6'b0) begin
      n_bad++; $display("FAIL reset_mid_busy: req/stall/valid/wrt/err/dump=%b, expected 000000",
                        {mem_req, stall, out_valid, out_reg_wrt, err, mem_createdump});
    end
    tick(); idle_in(); rst = 1;
    mem_done = 1; mem_rdata = 16'hDEAD;
    tick(); mem_done = 0;
    n_cmp++;
    if (out_valid !== 0) begin
      n_bad++; $display("FAIL late_done_ignored: out_valid=%b, expected 0", out_valid);
    end
    in_valid = 1; wb_src_in = 3'd3; set_val = 16'h5A5A; reg_wrt_in = 1;
    push(16'h5A5A, 1, 1);
    tick(); idle_in();
    n_cmp++;
    if (out_valid !== 1 || out_wb_data !== 16'h5A5A) begin
      n_bad++; $display("FAIL post_reset_alu: valid=%b data=%h, expected 1 5a5a", out_valid, out_wb_data);
    end
    tick();
  endtask

  task automatic test_halt();
    in_valid = 1; halt = 1; wb_src_in = 3'd2; next_pc = 16'h0200; reg_wrt_in = 0;
    push(16'h0200, 0, 1);
    #1;
    n_cmp++;
    if (stall !== 0) begin
      n_bad++; $display("FAIL halt_stall: stall=%b, expected 0", stall);
    end
    tick(); idle_in();
    n_cmp++;
    if (mem_createdump !== 1 || out_valid !== 1) begin
      n_bad++; $display("FAIL halt_dump: dump=%b valid=%b, expected 1 1", mem_createdump, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; mem_en = (i != 1); wb_src_in = (i == 2) ? 3'd7 : 3'd1; alu_out = 16'(i);
      #1;
      n_cmp++;
      if (mem_req !== 0 || stall !== 0) begin
        n_bad++; $display("FAIL halted_req%0d: req=%b stall=%b, expected 0 0", i, mem_req, stall);
      end
      tick();
      n_cmp++;
      if (out_valid !== 0 || mem_createdump !== 0 || err !== 0) begin
        n_bad++; $display("FAIL halted_out%0d: valid=%b dump=%b err=%b, expected 0 0 0", i, out_valid, mem_createdump, err);
      end
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_alu();
    test_load();
    test_back_to_back();
    test_illegal();
    do_reset();
    test_timeout();
    test_reset_mid_busy();
    test_halt();
    tick(); tick();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++; $display("FAIL sb_drain: %0d results still pending, expected 0", q.size());
    end
    n_cmp++;
    if (n_dump != 3) begin
      n_bad++; $display("FAIL dump_count: got %0d dump pulses, expected 3", n_dump);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
